// File: rtl/bitstream_window_buffer.sv
// Bit-granular stream window: words go into a ring, and a PEEK_W-bit MSB-first
// window is read out. Bits are consumed by an advance of a given length or by an alignment to the next byte.
module bitstream_window_buffer #(
  parameter int IN_W        = 16,
  parameter int DEPTH_WORDS = 8,
  parameter int PEEK_W      = 32,
  localparam int RING       = DEPTH_WORDS * IN_W,
  localparam int LW         = $clog2(RING + 1),
  localparam int AW         = $clog2(PEEK_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              adv_valid,
  input  logic [AW-1:0]     adv_len,
  input  logic              align_req,
  output logic [PEEK_W-1:0] peek_data,
  output logic              peek_valid,
  output logic [LW-1:0]     level,
  output logic [31:0]       bit_pos,
  output logic              err_underflow
);

  localparam int RW  = $clog2(RING);
  localparam int RW1 = RW + 1;
  localparam int WPW = $clog2(DEPTH_WORDS);
  localparam int CW  = (LW > AW) ? LW + 1 : AW + 1;

  logic [IN_W-1:0] r_ring [DEPTH_WORDS];
  logic [WPW-1:0]  r_wp;
  logic [RW-1:0]   r_rp;
  logic [LW-1:0]   r_level;
  logic [31:0]     r_bit_pos;
  logic            r_err;

  logic [IN_W-1:0] w_in_rev;
  logic [RING-1:0] w_flat;
  logic            w_wr;
  logic            w_adv_ok;
  logic [AW-1:0]   w_adv_amt;
  logic [LW-1:0]   w_lvl_after_adv;
  logic [31:0]     w_pos_after_adv;
  logic [2:0]      w_d;
  logic            w_align_ok;
  logic [2:0]      w_drop;
  logic            w_err_set;
  logic [RW1-1:0]  w_rp_sum;
  logic [RW-1:0]   w_rp_next;
  logic [LW-1:0]   w_level_next;

  // Ring bit 0 of each word holds the earliest stream bit, so ring bit order is stream order.
  genvar gi;
  generate
    for (gi = 0; gi < IN_W; gi++) begin : g_rev
      assign w_in_rev[gi] = in_data[IN_W-1-gi];
    end
    for (gi = 0; gi < DEPTH_WORDS; gi++) begin : g_flat
      assign w_flat[gi*IN_W +: IN_W] = r_ring[gi];
    end
  endgenerate

  assign in_ready   = (r_level <= LW'(RING - IN_W));
  assign peek_valid = (r_level >= LW'(PEEK_W));
  assign level         = r_level;
  assign bit_pos       = r_bit_pos;
  assign err_underflow = r_err;

  assign w_wr      = in_valid && in_ready;
  assign w_adv_ok  = adv_valid && (CW'(adv_len) <= CW'(r_level)) && (CW'(adv_len) <= CW'(PEEK_W));
  assign w_adv_amt = w_adv_ok ? adv_len : '0;

  assign w_lvl_after_adv = r_level - LW'(w_adv_amt);
  assign w_pos_after_adv = r_bit_pos + 32'(w_adv_amt);
  assign w_d             = 3'd0 - w_pos_after_adv[2:0];
  // A word written this cycle is not yet consumable, so alignment only sees the old bits.
  assign w_align_ok      = align_req && (LW'(w_d) <= w_lvl_after_adv);
  assign w_drop          = w_align_ok ? w_d : 3'd0;
  assign w_err_set       = (adv_valid && !w_adv_ok) || (align_req && !w_align_ok);

  assign w_level_next = w_lvl_after_adv - LW'(w_drop) + (w_wr ? LW'(IN_W) : LW'(0));

  // Total step is below RING, so a single conditional subtract keeps the pointer in range.
  assign w_rp_sum  = {1'b0, r_rp} + RW1'(w_adv_amt) + RW1'(w_drop);
  assign w_rp_next = (w_rp_sum >= RW1'(RING)) ? RW'(w_rp_sum - RW1'(RING)) : RW'(w_rp_sum);

  generate
    for (gi = 0; gi < PEEK_W; gi++) begin : g_peek
      logic [RW1-1:0] w_sum;
      logic [RW-1:0]  w_idx;
      assign w_sum = {1'b0, r_rp} + RW1'(gi);
      assign w_idx = (w_sum >= RW1'(RING)) ? RW'(w_sum - RW1'(RING)) : RW'(w_sum);
      assign peek_data[PEEK_W-1-gi] = (LW'(gi) < r_level) ? w_flat[w_idx] : 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset && w_wr) begin
      r_ring[r_wp] <= w_in_rev;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_level   <= '0;
      r_bit_pos <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + WPW'(1);
      end
      r_rp      <= w_rp_next;
      r_level   <= w_level_next;
      r_bit_pos <= w_pos_after_adv + 32'(w_drop);
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/bitstream_window_buffer.md
BITSTREAM_WINDOW_BUFFER -- requirements
Module: bitstream_window_buffer

Interface
REQ-001 SHALL have parameter IN_W, default 16: input word width in bits; multiple of 8, at least 8.
REQ-002 SHALL have parameter DEPTH_WORDS, default 8: ring depth in words; power of two, at least 4.
REQ-003 SHALL have parameter PEEK_W, default 32: peek window width in bits; at most (DEPTH_WORDS-1)*IN_W.
REQ-004 SHALL have derived width LW = clog2(DEPTH_WORDS*IN_W+1) for level, and AW = clog2(PEEK_W+1) for advance length.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_data  in  IN_W  stream word, MSB is the earliest bit.
REQ-008 in_valid  in  1  in_data is valid.
REQ-009 in_ready  out  1  buffer can accept one word this cycle.
REQ-010 adv_valid  in  1  consume adv_len bits this cycle.
REQ-011 adv_len  in  AW  number of bits to consume, 0..PEEK_W.
REQ-012 align_req  in  1  discard bits up to the next byte boundary.
REQ-013 peek_data  out  PEEK_W  next PEEK_W unconsumed bits, MSB first.
REQ-014 peek_valid  out  1  level >= PEEK_W.
REQ-015 level  out  LW  count of unconsumed bits held.
REQ-016 bit_pos  out  32  total bits consumed since reset; wraps modulo 2^32.
REQ-017 err_underflow  out  1  sticky; set by an illegal advance.

Function
REQ-018 Storage SHALL be a ring of DEPTH_WORDS*IN_W bits, with a word-granular write pointer and a bit-granular read pointer, both wrapping modulo the ring size.
REQ-019 in_ready SHALL be 1 when (DEPTH_WORDS*IN_W - level) >= IN_W, evaluated from registered state only.
REQ-020 A word SHALL be accepted when in_valid && in_ready; it is written at the write pointer and the pointer advances by 1 word at the next edge.
REQ-021 in_valid while in_ready=0 SHALL be ignored; no state changes.
REQ-022 peek_data SHALL be combinational from registered state (zero latency): bit PEEK_W-1 is the bit at the read pointer, reading across the ring wrap seamlessly.
REQ-023 Bits of peek_data beyond level SHALL read 0.
REQ-024 An advance SHALL be legal when adv_valid && adv_len <= level; at the next edge the read pointer, bit_pos and level (reduction) each change by adv_len.
REQ-025 An illegal advance (adv_len > level, or adv_len > PEEK_W) SHALL cause no pointer or level change and SHALL set err_underflow, which stays set until reset.
REQ-026 adv_len = 0 with adv_valid SHALL be a legal no-op.
REQ-027 align_req SHALL discard d = (8 - (bit_pos mod 8)) mod 8 bits, with bit_pos taken after any same-cycle advance; when d > level the request is ignored and err_underflow is set.
REQ-028 Simultaneous write, advance and align SHALL combine in one cycle: new level = level + IN_W*write - adv_len - d; no bubble cycles.
REQ-029 A word SHALL be consumable in the cycle after acceptance, not in the same cycle.
REQ-030 When the buffer is full, in_ready=0 while an advance proceeds; in_ready SHALL reassert on the following cycle once space >= IN_W.
REQ-031 When the buffer is empty (level=0), peek_data=0 and peek_valid=0; the legal operations are adv_len=0 and align with d=0.

Reset
REQ-032 While reset=1 at an edge, the following SHALL be cleared: pointers=0, level=0, bit_pos=0, err_underflow=0. Consequently peek_data=0, peek_valid=0, and in_ready=1.
REQ-033 Reset SHALL take priority over a simultaneous write, advance or align; in-flight data is discarded.
REQ-034 Ring storage contents need not be cleared; the masking in REQ-023 hides stale bits.

Verification
REQ-035 Defaults; reset; write 0xA5C3 then 0x1234 -> level=32, peek_valid=1, peek_data=0xA5C31234, in_ready=1.
REQ-036 From REQ-035 state, advance 5 -> level=27, bit_pos=5, peek_data=0xB8624680 (zeros fill the low bits); then align -> d=3, level=24, bit_pos=8, peek_data=0xC3123400.
REQ-037 Fill 8 words with in_valid held high -> in_ready=0 after the 8th, level=128; advance 16 with in_valid=1 -> next cycle in_ready=1, and a 9th word is written across the ring wrap; peek reads continuous data across the wrap.
REQ-038 With level=10, advance 11 -> no state change, err_underflow=1 and it persists; a following advance 10 succeeds -> level=0, peek_data=0.
REQ-039 Same-cycle write 0xFFFF, advance 7 and align at bit_pos=0, level=16 -> level=24, bit_pos=8.
REQ-040 Assert reset mid-stream (level=48, err_underflow=1) together with a write -> next cycle level=0, bit_pos=0, err_underflow=0, in_ready=1, and the written word is discarded.
